uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style, oversampled) feeding a first-word-fall-through FIFO.
// Optional parity bit support is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int unsigned word_width = 8,
  parameter int unsigned oversample = 16,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX,
  input  logic [15:0]                   baud_div,
  input  logic                          parity_odd,
  input  logic                          rd,
  output logic [word_width-1:0]         D_OUT,
  output logic                          valid,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          R_locked,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  localparam int unsigned AW   = $clog2(fifo_depth);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(oversample);
  localparam int unsigned BW   = $clog2(word_width);

  localparam logic [CW-1:0]   TICK_LAST = CW'(oversample - 1);
  localparam logic [CW-1:0]   TICK_HALF = CW'(oversample / 2 - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(word_width - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(fifo_depth);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;
  logic [15:0]           presc_q, presc_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]            state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [word_width-1:0] shreg_q, shreg_d;
  logic                  locked_q, locked_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif

  logic [word_width-1:0] mem_q [fifo_depth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  valid_q, valid_d;
  logic [word_width-1:0] dout_q, dout_d;

  logic tick_c;
  logic tick_wrap_c;
  logic push_c;
  logic pop_c;
  logic full_c;
  logic wr_en_c;

  assign tick_c      = (presc_q == 16'd0);
  assign tick_wrap_c = (tick_cnt_q == TICK_LAST);

  // Synchroniser, prescaler and receive state machine next-state logic.
  always_comb begin
    rx_meta_d   = RX;
    rx_s_d      = rx_meta_q;
    presc_d     = tick_c ? baud_div : presc_q - 16'd1;
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (tick_c) begin
      tick_cnt_d = tick_wrap_c ? '0 : CW'(tick_cnt_q + 1'b1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick_c && !rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        // Mid-start-bit recheck rejects glitches shorter than half a bit.
        if (tick_c && (tick_cnt_q == TICK_HALF)) begin
          tick_cnt_d = '0;
          bit_d      = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
          state_d    = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_c && tick_wrap_c) begin
          shreg_d = {rx_s_q, shreg_q[word_width-1:1]};
          bit_d   = BW'(bit_q + 1'b1);
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_c && tick_wrap_c) begin
          par_bad_d = (((^shreg_q) ^ rx_s_q) != parity_odd);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick_c && tick_wrap_c) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
            push_c       = !par_bad_q;
`else
            push_c       = 1'b1;
`endif
            state_d      = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    locked_d = (state_d != S_IDLE);
  end

  assign pop_c   = rd && valid_q;
  assign full_c  = (count_q == CNT_FULL);
  assign wr_en_c = push_c && (!full_c || pop_c);

  // FIFO bookkeeping; the head word is kept in its own register.
  always_comb begin
    overflow_d = push_c && full_c && !pop_c;
    wr_ptr_d   = wr_en_c ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en_c && !pop_c) begin
      count_d = CNTW'(count_q + 1'b1);
    end else if (!wr_en_c && pop_c) begin
      count_d = CNTW'(count_q - 1'b1);
    end
    valid_d = (count_d != '0);

    if (count_d == '0) begin
      dout_d = '0;
    end else if (wr_en_c && ((count_q == '0) || (pop_c && (count_q == CNTW'(1))))) begin
      dout_d = shreg_q;
    end else if (pop_c) begin
      dout_d = mem_q[AW'(rd_ptr_q + 1'b1)];
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bit_q       <= '0;
      shreg_q     <= '0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err        = 1'b0;
`endif

  // Storage array needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  assign D_OUT     = dout_q;
  assign valid     = valid_q;
  assign count     = count_q;
  assign R_locked  = locked_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: randomized and directed frames against a queue model.
module tb_uart_rx_fifo;

  localparam int W     = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = W + PAR + 1;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic [15:0] baud_div;
  logic        parity_odd;
  logic        rd;
  logic [W-1:0] D_OUT;
  logic        valid;
  logic [3:0]  count;
  logic        R_locked;
  logic        frame_err;
  logic        parity_err;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_data[$];
  int           exp_flag[$];

  uart_rx_fifo #(.word_width(W), .oversample(OS), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .baud_div(baud_div), .parity_odd(parity_odd),
    .rd(rd), .D_OUT(D_OUT), .valid(valid), .count(count), .R_locked(R_locked),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endfunction

  // Flag kinds: 1 = frame_err, 2 = parity_err, 3 = overflow.
  function automatic void flag_seen(input int kind, input string name);
    if (exp_flag.size() == 0) chk(name, kind, 0);
    else chk(name, kind, exp_flag.pop_front());
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd && valid) begin
        if (exp_data.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_data", D_OUT, exp_data.pop_front());
      end
      if (frame_err)  flag_seen(1, "frame_err");
      if (parity_err) flag_seen(2, "parity_err");
      if (overflow)   flag_seen(3, "overflow");
    end
  end

  function automatic int bit_clks();
    return OS * (int'(baud_div) + 1);
  endfunction

  task automatic expect_frame(input logic [W-1:0] d, input logic stop, input logic pflip);
    if (!stop) exp_flag.push_back(1);
`ifdef UART_RX_PARITY_EN
    else if (pflip) exp_flag.push_back(2);
`endif
    else if (exp_data.size() >= DEPTH) exp_flag.push_back(3);
    else exp_data.push_back(d);
`ifndef UART_RX_PARITY_EN
    if (pflip) ;
`endif
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (bit_clks()) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [W-1:0] d, input logic stop, input logic pflip);
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((parity_odd ? ~(^d) : (^d)) ^ pflip);
`else
    if (pflip) ;
`endif
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic stop, input logic pflip);
    expect_frame(d, stop, pflip);
    drive_frame(d, stop, pflip);
    idle(bit_clks() + 4);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd = 1'b1;
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
  endtask

  task automatic wait_lock(output int ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (R_locked) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic time_unlock(output int n);
    n = 0;
    while (R_locked && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int ok;
    int n;
    logic [W-1:0] d;
    logic stop;
    logic pflip;

    rst_n = 1'b0; RX = 1'b1; baud_div = 16'd0; parity_odd = 1'b0; rd = 1'b0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dout", D_OUT, 0);
    chk("rst_locked", R_locked, 0);
    chk("rst_flags", {frame_err, parity_err, overflow}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);

    // Single good frame: head appears one clock after the stop sample.
    expect_frame(8'h5A, 1'b1, 1'b0);
    fork
      drive_frame(8'h5A, 1'b1, 1'b0);
      begin
        wait_lock(ok);
        chk("lock_seen_5a", ok, 1);
        if (ok == 1) begin
          repeat (7 + OS * NBITS) @(posedge clk);
          @(negedge clk);
          chk("valid_before_stop", valid, 0);
          @(negedge clk);
          chk("valid_after_stop", valid, 1);
          chk("dout_5a", D_OUT, 8'h5A);
          chk("count_5a", count, 1);
        end
      end
    join
    idle(20);
    pop_n(1);
    chk("count_after_pop", count, 0);

    // Short low glitch is a false start.
    fork
      begin
        RX = 1'b0;
        repeat (4) @(posedge clk);
        #1 RX = 1'b1;
      end
      begin
        wait_lock(ok);
        chk("lock_seen_glitch", ok, 1);
        time_unlock(n);
        chk("glitch_unlock_le9", (n <= 9), 1);
      end
    join
    idle(40);
    chk("glitch_count", count, 0);

    // Stop bit low, then line held low.
    expect_frame(8'hFF, 1'b0, 1'b0);
    drive_frame(8'hFF, 1'b0, 1'b0);
    repeat (3 * bit_clks()) @(posedge clk);
    #1;
    chk("break_locked", R_locked, 1);
    chk("break_pending_flags", exp_flag.size(), 0);
    RX = 1'b1;
    time_unlock(n);
    chk("break_unlock", (n <= 5), 1);
    idle(40);
    chk("break_count", count, 0);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send(8'h03, 1'b1, 1'b1);
    chk("parity_bad_count", count, 0);
    chk("parity_pending_flags", exp_flag.size(), 0);
    parity_odd = 1'b1;
    send(8'hA7, 1'b1, 1'b0);
    chk("parity_odd_count", count, 1);
    pop_n(1);
    parity_odd = 1'b0;
`endif

    // Randomized frames and pops.
    for (int f = 0; f < 24; f++) begin
      if (f % 6 == 0) begin
        baud_div = 16'($urandom_range(0, 2));
        idle(120);
      end
      d     = W'($urandom);
      stop  = ($urandom_range(0, 7) != 0);
      pflip = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'($urandom);
`endif
      send(d, stop, pflip);
      chk("rand_count", count, exp_data.size());
      chk("rand_valid", valid, (exp_data.size() != 0));
      chk("rand_locked", R_locked, 0);
      chk("rand_pending_flags", exp_flag.size(), 0);
      if (exp_data.size() >= 4 || $urandom_range(0, 3) == 0) begin
        pop_n($urandom_range(0, exp_data.size()));
        chk("rand_count_pop", count, exp_data.size());
      end
    end
    pop_n(exp_data.size());
    baud_div = 16'd0;
    parity_odd = 1'b0;
    idle(120);
    chk("drained_count", count, 0);

    // Nine frames without reads: last one overflows.
    for (int i = 0; i < 9; i++) send(W'($urandom), 1'b1, 1'b0);
    chk("full_count", count, DEPTH);
    chk("full_pending_flags", exp_flag.size(), 0);

    // Pop in the push clock of a full FIFO: no overflow, newest at tail.
    d = 8'hC3;
    exp_data.push_back(d);
    fork
      drive_frame(d, 1'b1, 1'b0);
      begin
        wait_lock(ok);
        chk("lock_seen_full", ok, 1);
        if (ok == 1) begin
          repeat (7 + OS * NBITS) @(posedge clk);
          #1 rd = 1'b1;
          @(posedge clk);
          #1 rd = 1'b0;
        end
      end
    join
    idle(40);
    chk("pushpop_count", count, DEPTH);
    chk("pushpop_pending_flags", exp_flag.size(), 0);
    pop_n(8);
    chk("final_drain_count", count, 0);
    chk("final_drain_valid", valid, 0);

    rd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd = 1'b0;
    chk("empty_rd_count", count, 0);

    // Reset in the middle of a frame.
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    chk("prereset_count", count, 2);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #3 rst_n = 1'b0;
    exp_data.delete();
    exp_flag.delete();
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_locked", R_locked, 0);
    chk("midrst_dout", D_OUT, 0);
    RX = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(60);
    chk("postrst_count", count, 0);
    send(8'h96, 1'b1, 1'b0);
    chk("postrst_frame_count", count, 1);
    pop_n(1);

    chk("end_pending_flags", exp_flag.size(), 0);
    chk("end_pending_data", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
